// File: rtl/ccr_unit.sv
// Condition-code register stage behind the execute-stage ALU.
// Holds {C,N,Z}, applies per-opcode flag updates, SETC/CLRC, clears the
// flag tested by a taken conditional jump, and keeps a small LIFO of saved
// CCR values for nested interrupt entry / RTI.
module ccr_unit #(
    parameter int DEPTH = 2,
    localparam int DW = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_stall,
    input  logic          i_alu_valid,
    input  logic [2:0]    i_alu_op,
    input  logic          i_zero_flag,
    input  logic          i_negative_flag,
    input  logic          i_carry_flag,
    input  logic          i_setc,
    input  logic          i_clrc,
    input  logic          i_jmp_valid,
    input  logic [1:0]    i_jmp_cond,
    input  logic          i_save,
    input  logic          i_restore,
    output logic [2:0]    o_ccr,
    output logic          o_jmp_taken,
    output logic [DW-1:0] o_depth,
    output logic          o_stack_overflow,
    output logic          o_stack_underflow
);

    // Stack index width; a single-entry stack still needs a 1-bit index.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    logic [2:0]    stack [DEPTH];
    logic [2:0]    next_ccr;
    logic          flag_sel;
    logic          not_empty;
    logic          not_full;
    logic          do_push;
    logic          do_pop;
    logic [IW-1:0] push_idx;
    logic [IW-1:0] top_idx;

    assign not_empty = (o_depth != '0);
    assign not_full  = (o_depth < FULL);
    assign do_pop    = i_restore & not_empty;
    assign do_push   = i_save & ~i_restore & not_full;
    // Out-of-range values only appear when the matching operation is blocked.
    assign push_idx  = IW'(o_depth);
    assign top_idx   = IW'(o_depth - DW'(1));

    // Jump decision from the registered CCR only; same-cycle ALU flags are not forwarded.
    always_comb begin
        flag_sel = 1'b1;
        case (i_jmp_cond)
            2'b00:   flag_sel = 1'b1;
            2'b01:   flag_sel = o_ccr[0];
            2'b10:   flag_sel = o_ccr[1];
            default: flag_sel = o_ccr[2];
        endcase
        o_jmp_taken = i_jmp_valid & ~i_stall & flag_sel;
    end

    // Next CCR: jump clear, then ALU update, then SETC/CLRC, later steps win per bit.
    always_comb begin
        next_ccr = o_ccr;
        if (o_jmp_taken) begin
            case (i_jmp_cond)
                2'b01:   next_ccr[0] = 1'b0;
                2'b10:   next_ccr[1] = 1'b0;
                2'b11:   next_ccr[2] = 1'b0;
                default: ;
            endcase
        end
        if (i_alu_valid) begin
            case (i_alu_op)
                3'b001, 3'b100, 3'b101: begin
                    next_ccr[0] = i_zero_flag;
                    next_ccr[1] = i_negative_flag;
                end
                3'b010, 3'b011, 3'b110, 3'b111: begin
                    next_ccr[0] = i_zero_flag;
                    next_ccr[1] = i_negative_flag;
                    next_ccr[2] = i_carry_flag;
                end
                default: ;
            endcase
        end
        if (i_setc & ~i_clrc) begin
            next_ccr[2] = 1'b1;
        end else if (i_clrc & ~i_setc) begin
            next_ccr[2] = 1'b0;
        end
    end

    // Shadow stack storage: pushes the post-update CCR; contents need no reset.
    always_ff @(posedge i_clk) begin
        if (~i_stall & do_push) begin
            stack[push_idx] <= next_ccr;
        end
    end

    // CCR, stack pointer and sticky error flags; restore takes priority over save.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_ccr             <= 3'b000;
            o_depth           <= '0;
            o_stack_overflow  <= 1'b0;
            o_stack_underflow <= 1'b0;
        end else if (~i_stall) begin
            if (do_pop) begin
                o_ccr   <= stack[top_idx];
                o_depth <= o_depth - DW'(1);
            end else begin
                o_ccr <= next_ccr;
                if (do_push) begin
                    o_depth <= o_depth + DW'(1);
                end
            end
            if (i_restore & ~not_empty) begin
                o_stack_underflow <= 1'b1;
            end
            if (i_save & ~i_restore & ~not_full) begin
                o_stack_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ccr_unit.md
Name: ccr_unit

Overview:
- Condition-code register (CCR) stage directly downstream of the execute-stage ALU.
- Latches the ALU zero/negative/carry flags under a per-opcode update mask.
- Applies SETC/CLRC, evaluates and clears flags for conditional jumps.
- Saves and restores the CCR on interrupt entry and RTI through a small shadow stack.

Parameters:
DEPTH, 2, number of shadow-stack entries for nested interrupts (1..8)

Ports:
i_clk  input  1  clock; all state updates on the rising edge
i_reset  input  1  asynchronous, active-high reset
i_stall  input  1  pipeline stall; freezes all state
i_alu_valid  input  1  ALU instruction in EX this cycle
i_alu_op  input  3  ALU opcode: 000 NOP, 001 NOT, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 SHL, 111 SHR
i_zero_flag  input  1  ALU zero flag
i_negative_flag  input  1  ALU negative flag
i_carry_flag  input  1  ALU carry flag
i_setc  input  1  SETC instruction
i_clrc  input  1  CLRC instruction
i_jmp_valid  input  1  conditional jump in EX
i_jmp_cond  input  2  00 unconditional, 01 JZ, 10 JN, 11 JC
i_save  input  1  interrupt entry: push CCR
i_restore  input  1  RTI: pop CCR
o_ccr  output  3  {C,N,Z}, registered
o_jmp_taken  output  1  combinational jump decision
o_depth  output  clog2(DEPTH+1)  occupied stack entries
o_stack_overflow  output  1  sticky push-when-full error
o_stack_underflow  output  1  sticky pop-when-empty error

Behaviour:
- Reset (asynchronous, any time, including mid-operation): o_ccr=000, stack emptied (o_depth=0), both error flags 0. Stack contents are don't-care.
- Stall: i_stall=1 → no state changes, all other inputs ignored, o_jmp_taken=0.
- o_jmp_taken = i_jmp_valid & ~i_stall & (cond==00 ? 1 : selected flag of the registered o_ccr). Z for 01, N for 10, C for 11.
  - Same-cycle ALU flags are not forwarded.
- The next-state CCR value (next) is computed from o_ccr in the priority order below; lower items override higher ones per bit.
  1. Jump clear: if the jump is taken and cond≠00, the tested flag is cleared.
  2. ALU update when i_alu_valid:
     - op 000: no bits updated.
     - ops 001/100/101: Z and N updated.
     - ops 010/011/110/111: Z, N and C updated.
  3. Carry instructions:
     - i_setc alone: C=1.
     - i_clrc alone: C=0.
     - Both asserted: C unchanged by this step.
- Stack operations:
  - Restore (i_restore=1, highest priority, save ignored):
    - If depth>0: o_ccr ← top entry, depth−1, and next is discarded.
    - If depth=0: o_ccr ← next, o_stack_underflow ← 1.
  - Save (i_save=1, i_restore=0):
    - If depth<DEPTH: push next (the post-update value), depth+1, and o_ccr ← next.
    - If full: no push, o_ccr ← next, o_stack_overflow ← 1.
  - Otherwise: o_ccr ← next.
- Stack is LIFO. Depth never exceeds DEPTH and never wraps below 0.
- All outputs except o_jmp_taken are registered; flag latency is 1 cycle from the ALU inputs.

Test Plan:
- Reset mid-run with o_ccr=111, depth=1, error flags set → same cycle: o_ccr=000, o_depth=0, both error flags 0.
- ADD with Z=0,N=1,C=1 → o_ccr=110. Then AND with Z=1,N=0,C=0 → o_ccr=101 (C kept). Then op 000 with flags 111 → o_ccr stays 101.
- o_ccr=001, JZ valid → o_jmp_taken=1 same cycle, next o_ccr=000. Repeat JZ → o_jmp_taken=0. Unconditional jump → taken, o_ccr unchanged.
- SETC with SUB producing C=0,Z=1,N=0 in the same cycle → o_ccr=101. SETC+CLRC together with o_ccr=100 → o_ccr=100.
- DEPTH=2: save at o_ccr=010, ADD sets 001, save → depth 2. Third save → o_stack_overflow=1, depth 2. Restore → 001, restore → 010, restore → o_stack_underflow=1, o_ccr holds 010.
- i_stall=1 with ALU flags 111, save, and JC valid → o_ccr, o_depth unchanged, o_jmp_taken=0.
